// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: LW/LBU/SW/SB over a single-outstanding data-memory port
module load_store_unit #(
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  rd_idx_i,
    output logic        mem_req_v_o,
    input  logic        mem_req_ready_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_resp_v_i,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_v_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        misaligned_o,
    output logic        timeout_o
);
    // op_i[1] selects store, op_i[0] selects byte width
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WB,
        S_ERR
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(RESP_TIMEOUT);

    state_t      state_q, state_d;
    logic        is_byte_q, is_byte_d;
    logic [1:0]  lane_q, lane_d;
    logic [4:0]  rd_q, rd_d;
    logic [15:0] timeout_cnt_q, timeout_cnt_d;
    logic        err_timeout_q, err_timeout_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;

    // Next-state and datapath decode; everything holds unless its state updates it
    always_comb begin
        state_d       = state_q;
        is_byte_d     = is_byte_q;
        lane_d        = lane_q;
        rd_d          = rd_q;
        timeout_cnt_d = timeout_cnt_q;
        err_timeout_d = err_timeout_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    is_byte_d = op_i[0];
                    lane_d    = addr_i[1:0];
                    rd_d      = rd_idx_i;
                    if (!op_i[0] && (addr_i[1:0] != 2'b00)) begin
                        // Word access off a word boundary: report, never touch memory
                        err_timeout_d = 1'b0;
                        state_d       = S_ERR;
                    end else begin
                        mem_we_d   = op_i[1];
                        mem_addr_d = {addr_i[31:2], 2'b00};
                        mem_be_d   = op_i[0] ? (4'b0001 << addr_i[1:0]) : 4'b1111;
                        if (!op_i[1]) begin
                            mem_wdata_d = 32'h0;
                        end else if (op_i[0]) begin
                            mem_wdata_d = {4{store_data_i[7:0]}};
                        end else begin
                            mem_wdata_d = store_data_i;
                        end
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready_i) begin
                    timeout_cnt_d = 16'h0;
                    state_d       = mem_we_q ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                // A response on the last counted cycle still wins over the timeout
                if (mem_resp_v_i) begin
                    wb_rd_d   = rd_q;
                    wb_data_d = is_byte_q ? {24'h0, mem_rdata_i[8*lane_q +: 8]} : mem_rdata_i;
                    state_d   = S_WB;
                end else if (timeout_cnt_q == TIMEOUT_LIMIT) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_ERR;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + 16'd1;
                end
            end
            S_WB:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any access without a pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            is_byte_q     <= 1'b0;
            lane_q        <= 2'b00;
            rd_q          <= 5'd0;
            timeout_cnt_q <= 16'h0;
            err_timeout_q <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'h0;
            mem_be_q      <= 4'h0;
            mem_wdata_q   <= 32'h0;
            wb_rd_q       <= 5'd0;
            wb_data_q     <= 32'h0;
        end else begin
            state_q       <= state_d;
            is_byte_q     <= is_byte_d;
            lane_q        <= lane_d;
            rd_q          <= rd_d;
            timeout_cnt_q <= timeout_cnt_d;
            err_timeout_q <= err_timeout_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
        end
    end

    // Valids and pulses decode from state only, so no input reaches an output combinationally
    always_comb begin
        ready_o      = (state_q == S_IDLE);
        mem_req_v_o  = (state_q == S_REQ);
        wb_v_o       = (state_q == S_WB);
        misaligned_o = (state_q == S_ERR) && !err_timeout_q;
        timeout_o    = (state_q == S_ERR) && err_timeout_q;
        mem_we_o     = mem_we_q;
        mem_addr_o   = mem_addr_q;
        mem_be_o     = mem_be_q;
        mem_wdata_o  = mem_wdata_q;
        wb_rd_o      = wb_rd_q;
        wb_data_o    = wb_data_q;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage placed directly downstream of the ALU. It accepts one load/store per transaction: the ALU-computed effective address, store data and destination register index. It drives a single-outstanding request/response data-memory port and returns load results to writeback. Handles word and unsigned-byte accesses, little-endian byte lanes, misalignment detection and a response timeout.

## Interface

Parameters:
- RESP_TIMEOUT, default 255: maximum cycles spent in WAIT before a load is abandoned; legal range 1..65535.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- valid_i  input  1  execute-side request valid.
- ready_o  output  1  unit can accept a request; asserted exactly when the state is IDLE.
- op_i  input  2  access type: 00 LW, 01 LBU, 10 SW, 11 SB.
- addr_i  input  32  effective byte address (ALU result).
- store_data_i  input  32  store source register value.
- rd_idx_i  input  5  load destination register index.
- mem_req_v_o  output  1  memory request valid.
- mem_req_ready_i  input  1  memory accepts the request this cycle.
- mem_we_o  output  1  1 = write, 0 = read.
- mem_addr_o  output  32  word-aligned address {addr[31:2],2'b00}.
- mem_be_o  output  4  byte enables.
- mem_wdata_o  output  32  write data.
- mem_resp_v_i  input  1  read response valid.
- mem_rdata_i  input  32  read response data.
- wb_v_o  output  1  one-cycle load-result valid.
- wb_rd_o  output  5  load destination index.
- wb_data_o  output  32  load result.
- misaligned_o  output  1  one-cycle pulse: word access with addr[1:0] != 0.
- timeout_o  output  1  one-cycle pulse: load response not received within RESP_TIMEOUT cycles.

## Operation

- FSM states: IDLE, REQ, WAIT, WB, ERR.
- IDLE: when valid_i is high, latch op, addr, store_data and rd_idx.
  - Misaligned LW/SW goes to ERR.
  - Any other access goes to REQ.
  - Byte accesses are never misaligned.
- REQ: mem_req_v_o=1 with stable address, we, be and wdata until mem_req_ready_i.
  - On that handshake, a store goes to IDLE and a load goes to WAIT.
  - There is no limit on the number of cycles spent in REQ.
- WAIT: a timeout counter starts at 0 on entry and increments each cycle without mem_resp_v_i.
  - mem_resp_v_i: latch the formatted result and go to WB.
  - Counter reaches RESP_TIMEOUT: go to ERR with the timeout cause.
- WB: wb_v_o=1 for exactly one cycle, then IDLE. Writeback cannot stall.
- ERR: pulse misaligned_o or timeout_o (never both), no memory request, then IDLE.
- Byte lanes (little-endian, lane k = bits 8k+7:8k):
  - LW/SW: be=4'b1111.
  - SB: be=1<<addr[1:0], wdata={4{store_data[7:0]}}.
  - LBU: wb_data={24'b0, rdata lane addr[1:0]}.
  - LW: wb_data=rdata.
  - Loads: mem_wdata_o=0.
- mem_resp_v_i outside WAIT is ignored, including a response arriving after a timeout.
- Outputs other than during their active state: mem_* and wb_data_o/wb_rd_o hold their last values, only valids gate them. Verification checks them only when the matching valid is high.

## Timing

- Reset values: state IDLE, ready_o=1, mem_req_v_o=0, mem_we_o=0, mem_addr_o=0, mem_be_o=0, mem_wdata_o=0, wb_v_o=0, wb_rd_o=0, wb_data_o=0, misaligned_o=0, timeout_o=0, timeout counter 0.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- Load, zero-wait memory (accept at T, ready at T+1, response at T+2):
  - REQ at T+1.
  - WAIT at T+2.
  - wb_v_o at T+3.
  - ready_o at T+4.
- Store: REQ at T+1, ready_o again at T+2. Each REQ stall cycle adds one cycle.
- Misaligned: misaligned_o at T+1, ready_o at T+2.
- Timeout: timeout_o asserted RESP_TIMEOUT+1 cycles after entering WAIT, then IDLE.
- mem_resp_v_i in the same cycle the counter reaches RESP_TIMEOUT: the response wins and goes to WB.
- Reset asserted mid-transaction: immediate return to IDLE with reset values. No pulse is emitted for the aborted access. Any later response is ignored.

## Test plan

- LW addr 0x100, memory returns 0xDEADBEEF one cycle after handshake -> be=1111, addr 0x100, wb_v_o at T+3 with rd and 0xDEADBEEF, ready_o at T+4.
- LBU addr 0x103, rdata 0xA1B2C3D4 -> wb_data 0x000000A1; addr 0x101 -> 0x000000C3.
- SB addr 0x202, data 0x12345678 with mem_req_ready_i low 3 cycles -> request stable for 4 cycles, be=0100, wdata 0x78787878, we=1, no wb_v_o.
- SW addr 0x206 -> misaligned_o single pulse at T+1, no mem_req_v_o ever, ready_o at T+2.
- RESP_TIMEOUT=4, LW without response -> timeout_o pulse, back to IDLE, no wb_v_o; a late mem_resp_v_i is then ignored. Also check a response on the final WAIT cycle still produces wb_v_o.
- Reset asserted asynchronously while in WAIT -> all outputs to reset values before next edge; a subsequent response produces no wb_v_o.
